mario_sprite_sequencer: RTL and testbench

- Animation controller and address generator for the big-Mario sprite ROM bank: stand, walk_right_1..3 and jump frames, each SPR_W x SPR_H = 21x41 = 861 entries, 4-bit palette index, 12-bit colour out.
- Picks the active frame from movement inputs, advances the walk cycle on vertical-frame ticks, and converts the raster position (DrawX, DrawY) into a ROM read_address.
- Adds horizontal mirroring for left-facing, a hit flag, and a transparency flag for the colour mapper.
- Sits between the Mario motion logic and the sprite ROMs / colour mapper.

---
 rtl/mario_pkg.sv | 16 +
 rtl/sprite_addr_gen.sv | 55 +++++
 rtl/mario_sprite_sequencer.sv | 113 +++++++++++
 tb/tb_mario_sprite_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared types and constants for the Mario sprite path
package mario_pkg;

    typedef enum logic [2:0] {
        STAND = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4
    } anim_state_t;

    localparam int          SPR_W_BIG    = 21;
    localparam int          SPR_H_BIG    = 41;
    localparam logic [11:0] TRANSP_COLOR = 12'h808;

endpackage

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - raster hit test, mirroring and ROM address stage
module sprite_addr_gen #(
    parameter int SPR_W  = 21,
    parameter int SPR_H  = 41,
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              facing_left,
    input  logic [9:0]        mario_x,
    input  logic [9:0]        mario_y,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] read_address,
    output logic              sprite_hit
);

    // 11-bit differences: bit 10 set means the raster is left of / above the sprite
    logic [10:0]       rel_x;
    logic [10:0]       rel_y;
    logic              hit;
    logic [9:0]        col;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              hit_q;

    assign rel_x = {1'b0, draw_x} - {1'b0, mario_x};
    assign rel_y = {1'b0, draw_y} - {1'b0, mario_y};

    // Hit test, optional horizontal mirror and row-major address
    always_comb begin
        hit    = !rel_x[10] && !rel_y[10]
              && (rel_x[9:0] < 10'(SPR_W)) && (rel_y[9:0] < 10'(SPR_H));
        col    = facing_left ? (10'(SPR_W - 1) - rel_x[9:0]) : rel_x[9:0];
        addr_d = '0;
        if (hit) begin
            addr_d = ADDR_W'(rel_y[9:0]) * ADDR_W'(SPR_W) + ADDR_W'(col);
        end
    end

    // One-cycle pipeline register toward the frame ROMs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            hit_q  <= hit;
        end
    end

    assign read_address = addr_q;
    assign sprite_hit   = hit_q;

endmodule

// File: rtl/mario_sprite_sequencer.sv
// rtl/mario_sprite_sequencer.sv - big-Mario animation FSM and sprite ROM addressing
module mario_sprite_sequencer
    import mario_pkg::*;
#(
    parameter int          SPR_W    = SPR_W_BIG,
    parameter int          SPR_H    = SPR_H_BIG,
    parameter int          ANIM_DIV = 6,
    parameter int          ADDR_W   = 10,
    parameter logic [11:0] TRANSP   = TRANSP_COLOR
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              on_ground,
    input  logic [9:0]        mario_x,
    input  logic [9:0]        mario_y,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] read_address,
    output logic [2:0]        frame_sel,
    output logic              sprite_hit,
    input  logic [11:0]       rom_color,
    output logic              pixel_on
);

    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    anim_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             facing_left_q, facing_left_d;
    logic             eff_l, eff_r, moving;

    assign eff_l  = move_left & ~move_right;
    assign eff_r  = move_right & ~move_left;
    assign moving = eff_l | eff_r;

    // Animation state, walk divider and facing register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= STAND;
            div_q         <= '0;
            facing_left_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            facing_left_q <= facing_left_d;
        end
    end

    // Next-state: only frame_tick cycles move the FSM, divider and facing
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        facing_left_d = facing_left_q;
        if (frame_tick) begin
            if (eff_l) facing_left_d = 1'b1;
            if (eff_r) facing_left_d = 1'b0;
            if (!on_ground) begin
                state_d = JUMP;
                div_d   = '0;
            end else begin
                unique case (state_q)
                    STAND, JUMP: begin
                        state_d = moving ? WALK1 : STAND;
                        div_d   = '0;
                    end
                    WALK1, WALK2, WALK3: begin
                        if (!moving) begin
                            state_d = STAND;
                            div_d   = '0;
                        end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                            div_d = '0;
                            case (state_q)
                                WALK1:   state_d = WALK2;
                                WALK2:   state_d = WALK3;
                                default: state_d = WALK1;
                            endcase
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = STAND;
                        div_d   = '0;
                    end
                endcase
            end
        end
    end

    assign frame_sel = state_q;

    sprite_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .facing_left  (facing_left_q),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .read_address (read_address),
        .sprite_hit   (sprite_hit)
    );

    assign pixel_on = sprite_hit && (rom_color != TRANSP);

endmodule

// File: tb/tb_mario_sprite_sequencer.sv
// tb/tb_mario_sprite_sequencer.sv - directed self-checking bench for mario_sprite_sequencer
module tb_mario_sprite_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic        on_ground = 1'b1;
    logic [9:0]  mario_x = '0;
    logic [9:0]  mario_y = '0;
    logic [9:0]  draw_x = 10'd500;
    logic [9:0]  draw_y = 10'd500;
    logic [9:0]  read_address;
    logic [2:0]  frame_sel;
    logic        sprite_hit;
    logic [11:0] rom_color = 12'h000;
    logic        pixel_on;

    int tests = 0;
    int fails = 0;

    mario_sprite_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .move_left    (move_left),
        .move_right   (move_right),
        .on_ground    (on_ground),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .read_address (read_address),
        .frame_sel    (frame_sel),
        .sprite_hit   (sprite_hit),
        .rom_color    (rom_color),
        .pixel_on     (pixel_on)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset;
        @(negedge Clk);
        Reset_n = 1'b0;
        frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0; on_ground = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic do_tick;
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd202;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        tests++;
        if (frame_sel !== 3'd0 || read_address !== 10'd0 || sprite_hit !== 1'b0 || pixel_on !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: frame_sel=%0d addr=%0d hit=%0b pix=%0b, want 0 0 0 0",
                     frame_sel, read_address, sprite_hit, pixel_on);
        end
        do_reset();
    endtask

    task automatic test_walk_cycle;
        int exp;
        do_reset();
        move_right = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            do_tick();
            exp = (t <= 6) ? 1 : (t <= 12) ? 2 : (t <= 18) ? 3 : 1;
            tests++;
            if (frame_sel !== 3'(exp)) begin
                fails++;
                $display("FAIL walk_tick%0d: frame_sel=%0d want %0d", t, frame_sel, exp);
            end
        end
        // no tick: frame must hold
        repeat (5) @(negedge Clk);
        tests++;
        if (frame_sel !== 3'd1) begin
            fails++;
            $display("FAIL walk_hold: frame_sel=%0d want 1", frame_sel);
        end
        move_right = 1'b0;
    endtask

    task automatic test_addr;
        do_reset();
        mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd202;
        @(negedge Clk);
        tests++;
        if (read_address !== 10'd47 || sprite_hit !== 1'b1) begin
            fails++;
            $display("FAIL addr_right: addr=%0d hit=%0b want 47 1", read_address, sprite_hit);
        end
        move_left = 1'b1;
        do_tick();
        move_left = 1'b0;
        @(negedge Clk);
        tests++;
        if (read_address !== 10'd57 || sprite_hit !== 1'b1) begin
            fails++;
            $display("FAIL addr_left: addr=%0d hit=%0b want 57 1", read_address, sprite_hit);
        end
        // tick turning right in the same cycle as a raster change: old facing used
        draw_x = 10'd106;
        move_right = 1'b1;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        move_right = 1'b0;
        tests++;
        if (read_address !== 10'd56) begin
            fails++;
            $display("FAIL addr_tick_same_cycle: addr=%0d want 56", read_address);
        end
        @(negedge Clk);
        tests++;
        if (read_address !== 10'd48) begin
            fails++;
            $display("FAIL addr_after_flip: addr=%0d want 48", read_address);
        end
        // bottom-right corner: last valid address
        draw_x = 10'd120; draw_y = 10'd240;
        @(negedge Clk);
        tests++;
        if (read_address !== 10'd860 || sprite_hit !== 1'b1) begin
            fails++;
            $display("FAIL addr_last: addr=%0d hit=%0b want 860 1", read_address, sprite_hit);
        end
    endtask

    task automatic test_miss;
        logic [9:0] vec [5][4];
        vec[0] = '{10'd100, 10'd200, 10'd99,  10'd202};
        vec[1] = '{10'd100, 10'd200, 10'd121, 10'd202};
        vec[2] = '{10'd100, 10'd200, 10'd105, 10'd241};
        vec[3] = '{10'd1015, 10'd200, 10'd3,  10'd202};
        vec[4] = '{10'd100, 10'd200, 10'd105, 10'd199};
        for (int i = 0; i < 5; i++) begin
            mario_x = vec[i][0]; mario_y = vec[i][1]; draw_x = vec[i][2]; draw_y = vec[i][3];
            @(negedge Clk);
            tests++;
            if (sprite_hit !== 1'b0 || read_address !== 10'd0) begin
                fails++;
                $display("FAIL miss%0d: hit=%0b addr=%0d want 0 0", i, sprite_hit, read_address);
            end
        end
    endtask

    task automatic test_jump_and_stand;
        do_reset();
        move_right = 1'b1;
        repeat (13) do_tick();
        tests++;
        if (frame_sel !== 3'd3) begin
            fails++;
            $display("FAIL pre_jump_walk3: frame_sel=%0d want 3", frame_sel);
        end
        on_ground = 1'b0;
        do_tick();
        tests++;
        if (frame_sel !== 3'd4) begin
            fails++;
            $display("FAIL jump: frame_sel=%0d want 4", frame_sel);
        end
        on_ground = 1'b1;
        move_right = 1'b0;
        do_tick();
        tests++;
        if (frame_sel !== 3'd0) begin
            fails++;
            $display("FAIL land_stand: frame_sel=%0d want 0", frame_sel);
        end
        // both held: no motion, facing stays right
        move_left = 1'b1; move_right = 1'b1;
        mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd202;
        do_tick();
        @(negedge Clk);
        tests++;
        if (frame_sel !== 3'd0 || read_address !== 10'd47) begin
            fails++;
            $display("FAIL both_held: frame_sel=%0d addr=%0d want 0 47", frame_sel, read_address);
        end
        move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic test_pixel_on;
        mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd202;
        rom_color = 12'h808;
        @(negedge Clk);
        tests++;
        if (pixel_on !== 1'b0) begin
            fails++;
            $display("FAIL pixel_transp: pixel_on=%0b want 0", pixel_on);
        end
        rom_color = 12'hF30;
        #1;
        tests++;
        if (pixel_on !== 1'b1) begin
            fails++;
            $display("FAIL pixel_opaque: pixel_on=%0b want 1", pixel_on);
        end
        draw_x = 10'd130;
        @(negedge Clk);
        tests++;
        if (pixel_on !== 1'b0) begin
            fails++;
            $display("FAIL pixel_miss: pixel_on=%0b want 0", pixel_on);
        end
    endtask

    task automatic test_reset_mid_walk;
        do_reset();
        mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd202;
        rom_color = 12'hF30;
        move_right = 1'b1;
        repeat (7) do_tick();
        tests++;
        if (frame_sel !== 3'd2 || sprite_hit !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_walk2: frame_sel=%0d hit=%0b want 2 1", frame_sel, sprite_hit);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        tests++;
        if (frame_sel !== 3'd0 || read_address !== 10'd0 || sprite_hit !== 1'b0 || pixel_on !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: frame_sel=%0d addr=%0d hit=%0b pix=%0b want 0 0 0 0",
                     frame_sel, read_address, sprite_hit, pixel_on);
        end
        move_right = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_walk_cycle();
        test_addr();
        test_miss();
        test_jump_and_stand();
        test_pixel_on();
        test_reset_mid_walk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
